pc_block: RTL and testbench

PC_BLOCK -- requirements
Module: pc_block

---
 rtl/pc_block_pkg.sv | 20 ++
 rtl/pc_next_mux.sv | 41 ++++
 rtl/pc_block.sv | 75 +++++++
 tb/tb_pc_block.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pc_block_pkg.sv
// Shared constants for the program-counter block: next-PC source encoding,
// the sequential increment and the default address width.
package pc_block_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int PC_INCREMENT  = 2;

  // Next-PC source select; codes 8..15 are unused and mean "hold".
  typedef enum logic [3:0] {
    PCSRC_INC    = 4'd0,
    PCSRC_IMMPC  = 4'd1,
    PCSRC_IMMABS = 4'd2,
    PCSRC_RA     = 4'd3,
    PCSRC_MARY   = 4'd4,
    PCSRC_PCMARY = 4'd5,
    PCSRC_JCMP   = 4'd6,
    PCSRC_JCMPLS = 4'd7
  } pc_src_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector. Produces the candidate next PC and a
// valid flag that is low for unused select codes, so the register holds.
module pc_next_mux
  import pc_block_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [3:0]       pc_src,
  input  logic [WIDTH-1:0] pc_cur,
  input  logic [WIDTH-1:0] imm_plus_pc,
  input  logic [WIDTH-1:0] imm_addr,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] mary,
  input  logic [WIDTH-1:0] pc_plus_mary,
  input  logic [WIDTH-1:0] jcmp_imm,
  input  logic [WIDTH-1:0] jcmp_imm_ls,
  output logic [WIDTH-1:0] next_pc,
  output logic             src_valid
);

  // Select the next PC; the increment wraps modulo 2^WIDTH naturally.
  always_comb begin
    next_pc   = pc_cur;
    src_valid = 1'b1;
    case (pc_src)
      PCSRC_INC:    next_pc = pc_cur + WIDTH'(PC_INCREMENT);
      PCSRC_IMMPC:  next_pc = imm_plus_pc;
      PCSRC_IMMABS: next_pc = imm_addr;
      PCSRC_RA:     next_pc = ra;
      PCSRC_MARY:   next_pc = mary;
      PCSRC_PCMARY: next_pc = pc_plus_mary;
      PCSRC_JCMP:   next_pc = jcmp_imm;
      PCSRC_JCMPLS: next_pc = jcmp_imm_ls;
      default: begin
        next_pc   = pc_cur;
        src_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_block.sv
// Program-counter register with write enable and synchronous reset.
// Optional feature macro PC_BLOCK_MISALIGN_FLAG_EN adds a sticky, registered
// pcMisaligned output that sets whenever an odd value is loaded.
module pc_block
  import pc_block_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       pcSrc,
  input  logic [WIDTH-1:0] immPlusPC,
  input  logic [WIDTH-1:0] immAddr,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] mary,
  input  logic [WIDTH-1:0] pcPlusMary,
  input  logic [WIDTH-1:0] jcmpImm,
  input  logic [WIDTH-1:0] jcmpImmLS,
  input  logic             pcWrite,
`ifdef PC_BLOCK_MISALIGN_FLAG_EN
  output logic             pcMisaligned,
`endif
  output logic [WIDTH-1:0] pcCur
);

  // Power-up value matches the reset value so pcCur is defined before reset.
  logic [WIDTH-1:0] pc_r = RESET_VALUE;
  logic [WIDTH-1:0] next_pc_s;
  logic             src_valid_s;
  logic             load_s;

  pc_next_mux #(.WIDTH(WIDTH)) u_next_mux (
    .pc_src       (pcSrc),
    .pc_cur       (pc_r),
    .imm_plus_pc  (immPlusPC),
    .imm_addr     (immAddr),
    .ra           (ra),
    .mary         (mary),
    .pc_plus_mary (pcPlusMary),
    .jcmp_imm     (jcmpImm),
    .jcmp_imm_ls  (jcmpImmLS),
    .next_pc      (next_pc_s),
    .src_valid    (src_valid_s)
  );

  assign load_s = pcWrite & src_valid_s;

  // PC register: reset dominates, otherwise load only on a valid enabled source.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= RESET_VALUE;
    end else if (load_s) begin
      pc_r <= next_pc_s;
    end
  end

  assign pcCur = pc_r;

`ifdef PC_BLOCK_MISALIGN_FLAG_EN
  logic misaligned_r = 1'b0;

  // Sticky flag: set on any odd load, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      misaligned_r <= 1'b0;
    end else if (load_s && next_pc_s[0]) begin
      misaligned_r <= 1'b1;
    end
  end

  assign pcMisaligned = misaligned_r;
`endif

endmodule

// File: tb/tb_pc_block.sv
// Self-checking bench for pc_block: directed steps, expected PC values from a
// small reference model pushed to a scoreboard and popped one edge later.
`timescale 1ns/1ps
module tb_pc_block;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  pcSrc = 4'd0;
  logic [15:0] immPlusPC = 16'h0, immAddr = 16'h0, ra = 16'h0, mary = 16'h0;
  logic [15:0] pcPlusMary = 16'h0, jcmpImm = 16'h0, jcmpImmLS = 16'h0;
  logic        pcWrite = 1'b0;
  logic [15:0] pcCur;
`ifdef PC_BLOCK_MISALIGN_FLAG_EN
  logic        pcMisaligned;
  logic        model_mis = 1'b0;
  logic        mis_q[$];
`endif

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] model_pc = 16'h0000;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  pc_block #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .pcSrc      (pcSrc),
    .immPlusPC  (immPlusPC),
    .immAddr    (immAddr),
    .ra         (ra),
    .mary       (mary),
    .pcPlusMary (pcPlusMary),
    .jcmpImm    (jcmpImm),
    .jcmpImmLS  (jcmpImmLS),
    .pcWrite    (pcWrite),
`ifdef PC_BLOCK_MISALIGN_FLAG_EN
    .pcMisaligned (pcMisaligned),
`endif
    .pcCur      (pcCur)
  );

  always #5 clock = ~clock;

  task automatic check_pc(input string tag, input logic [15:0] exp);
    total_cnt++;
    assert (pcCur === exp) pass_cnt++;
    else $error("FAIL %s: pcCur=%h expected %h", tag, pcCur, exp);
  endtask

  // Apply current inputs for one edge; model predicts, scoreboard compares.
  task automatic step(input string tag);
    logic [15:0] e;
    e = model_pc;
    if (reset) e = 16'h0000;
    else if (pcWrite) begin
      case (pcSrc)
        4'd0: e = model_pc + 16'd2;
        4'd1: e = immPlusPC;
        4'd2: e = immAddr;
        4'd3: e = ra;
        4'd4: e = mary;
        4'd5: e = pcPlusMary;
        4'd6: e = jcmpImm;
        4'd7: e = jcmpImmLS;
        default: e = model_pc;
      endcase
    end
`ifdef PC_BLOCK_MISALIGN_FLAG_EN
    if (reset) model_mis = 1'b0;
    else if (pcWrite && pcSrc < 4'd8 && e[0]) model_mis = 1'b1;
    mis_q.push_back(model_mis);
`endif
    model_pc = e;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    check_pc(tag_q.pop_front(), exp_q.pop_front());
`ifdef PC_BLOCK_MISALIGN_FLAG_EN
    begin
      logic em;
      em = mis_q.pop_front();
      total_cnt++;
      assert (pcMisaligned === em) pass_cnt++;
      else $error("FAIL %s_mis: pcMisaligned=%b expected %b", tag, pcMisaligned, em);
    end
`endif
  endtask

  initial begin
    #1;
    check_pc("init", 16'h0000);

    reset = 1'b1; pcWrite = 1'b1; pcSrc = 4'd2; immAddr = 16'h1234;
    step("reset1");
    step("reset2");
    reset = 1'b0; pcWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pcSrc = 4'(i + 1);
      immPlusPC = ~immPlusPC; immAddr = ~immAddr; ra = ~ra; mary = ~mary;
      pcPlusMary = ~pcPlusMary; jcmpImm = ~jcmpImm; jcmpImmLS = ~jcmpImmLS;
      step("hold_nowrite");
    end

    pcWrite = 1'b1; pcSrc = 4'd2; immAddr = 16'h0000;
    step("abs0");
    immAddr = 16'h0002;
    step("abs2");
    pcSrc = 4'd0;
    for (int i = 0; i < 5; i++) step("inc");

    pcSrc = 4'd2; immAddr = 16'hFFFE;
    step("abs_fffe");
    pcSrc = 4'd0;
    step("wrap_fffe");
    pcSrc = 4'd2; immAddr = 16'hFFFF;
    step("abs_ffff");
    pcSrc = 4'd0;
    step("wrap_ffff");

    immPlusPC = 16'd1; ra = 16'd3; mary = 16'd4; pcPlusMary = 16'd5;
    jcmpImm = 16'd6; jcmpImmLS = 16'd7; immAddr = 16'hA5A5;
    pcSrc = 4'd1; step("src1");
    pcSrc = 4'd3; step("src3");
    pcSrc = 4'd4; step("src4");
    pcSrc = 4'd5; step("src5");
    pcSrc = 4'd6; step("src6");
    pcSrc = 4'd7; step("src7");
    pcSrc = 4'd2; step("src2");

    pcSrc = 4'd9;  step("src9_hold");
    pcSrc = 4'd8;  step("src8_hold");
    pcSrc = 4'd15; step("src15_hold");

    pcSrc = 4'd0;
    step("pre_rst_inc");
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;
    step("post_rst_inc");
    step("post_rst_inc2");

    pcWrite = 1'b0; reset = 1'b1;
    step("reset_nowrite");
    reset = 1'b0; pcSrc = 4'd1; pcWrite = 1'b1;
    step("odd_load");
    pcSrc = 4'd2; immAddr = 16'd2;
    step("even_after_odd");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
